// File: rtl/icetap_pkg.sv
// ---------------------------------------------------------------------------
// icetap_pkg
// Shared definitions for the icetap clock-crossing blocks.
//   state_t : receive-side handshake FSM encoding (2 bits)
// ---------------------------------------------------------------------------
package icetap_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_ACK     = 2'd2
  } state_t;

endpackage

// File: rtl/sync_dd_a.sv
// ---------------------------------------------------------------------------
// sync_dd_a
// Two-flop level synchronizer with asynchronous active-low reset.
//   clk    : destination clock
//   reset_ : asynchronous active-low reset, clears both stages
//   d      : asynchronous input level
//   q      : d resynchronized into clk (two cycles of latency)
// ---------------------------------------------------------------------------
module sync_dd_a (
  input  logic clk,
  input  logic reset_,
  input  logic d,
  output logic q
);

  logic meta;

  // First stage may go metastable; only the second stage is observed.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/hs_cdc_rx.sv
// ---------------------------------------------------------------------------
// hs_cdc_rx
// Receive side of a four-phase req/ack crossing. The sender holds data_in
// stable and raises req_in; the word is captured once req_in has been
// synchronized, offered on a valid/ready port, then acknowledged back.
//   clk, reset_ : local clock, asynchronous active-low reset
//   req_in      : sender request (foreign domain, synchronized internally)
//   data_in     : sender word, sampled only in the capture cycle
//   ack_out     : registered acknowledge to the sender
//   out_valid   : captured word available
//   out_data    : captured word, constant while out_valid is high
//   out_ready   : local consumer accepts the word
//   err         : sticky flag, sender dropped req before acknowledge
//   err_clr     : synchronous clear of err (a simultaneous new error wins)
//   xfer_cnt    : completed handshakes, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module hs_cdc_rx
  import icetap_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              req_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              ack_out,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              err,
  input  logic              err_clr,
  output logic [CNT_W-1:0]  xfer_cnt
);

  logic   req_s;
  state_t state;
  state_t next_state;
  logic   load;
  logic   set_err;
  logic   inc_cnt;

  sync_dd_a u_req_sync (
    .clk    (clk),
    .reset_ (reset_),
    .d      (req_in),
    .q      (req_s)
  );

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) state <= ST_IDLE;
    else         state <= next_state;
  end

  // A drop of req_s while presenting is only noticed when the word is taken;
  // the word is still delivered, but the sender is never acknowledged.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    set_err    = 1'b0;
    inc_cnt    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_s) begin
          load       = 1'b1;
          next_state = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (out_ready) begin
          if (req_s) begin
            next_state = ST_ACK;
          end else begin
            set_err    = 1'b1;
            next_state = ST_IDLE;
          end
        end
      end
      ST_ACK: begin
        if (!req_s) begin
          inc_cnt    = 1'b1;
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // ack_out leaves this clock domain, so it comes straight from its own flop
  // rather than a decode of the state bits; out_valid is registered alike.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      ack_out   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      ack_out   <= (next_state == ST_ACK);
      out_valid <= (next_state == ST_PRESENT);
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_)   out_data <= '0;
    else if (load) out_data <= data_in;
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_)      err <= 1'b0;
    else if (set_err) err <= 1'b1;
    else if (err_clr) err <= 1'b0;
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_)      xfer_cnt <= '0;
    else if (inc_cnt) xfer_cnt <= xfer_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_hs_cdc_rx.sv
// ---------------------------------------------------------------------------
// tb_hs_cdc_rx
// Self-checking bench for hs_cdc_rx (DATA_W=8, CNT_W=4).
// ---------------------------------------------------------------------------
module tb_hs_cdc_rx;

  logic       clk;
  logic       reset_;
  logic       req_in;
  logic [7:0] data_in;
  logic       ack_out;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       err;
  logic       err_clr;
  logic [3:0] xfer_cnt;

  int checks;
  int passed;

  typedef struct {
    logic       req;
    logic [7:0] data;
    logic       ready;
    logic       clr;
    logic       ack;
    logic       valid;
    logic [7:0] odata;
    logic       err;
    logic [3:0] cnt;
  } vec_t;

  vec_t vecs[25];

  logic [7:0] sentQ[$];
  int         recvCount;
  logic       senderDone;

  hs_cdc_rx #(
    .DATA_W (8),
    .CNT_W  (4)
  ) dut (
    .clk       (clk),
    .reset_    (reset_),
    .req_in    (req_in),
    .data_in   (data_in),
    .ack_out   (ack_out),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .err       (err),
    .err_clr   (err_clr),
    .xfer_cnt  (xfer_cnt)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance to just after the next active edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic applyStimulus(input vec_t v);
    req_in    = v.req;
    data_in   = v.data;
    out_ready = v.ready;
    err_clr   = v.clr;
  endtask

  // Wait for ack_out to reach a level; an exhausted budget is a failure
  task automatic waitAck(input logic level, input int budget, input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (ack_out == level) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput(name, 32'(seen), 32'd1);
  endtask

  task automatic doReset();
    reset_    = 1'b0;
    req_in    = 1'b0;
    data_in   = 8'h00;
    out_ready = 1'b0;
    err_clr   = 1'b0;
    tick();
    tick();
    reset_ = 1'b1;
    tick();
  endtask

  task automatic doHandshake(input logic [7:0] d);
    out_ready = 1'b1;
    data_in   = d;
    req_in    = 1'b1;
    waitAck(1'b1, 20, "hs_ack_high");
    req_in = 1'b0;
    waitAck(1'b0, 20, "hs_ack_low");
  endtask

  initial begin
    checks = 0;
    passed = 0;

    // Each row: inputs applied before an edge, outputs expected after it
    vecs[0]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0};
    vecs[1]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0};
    vecs[2]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 4'd0};
    vecs[3]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 4'd0};
    vecs[4]  = '{1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 4'd0};
    vecs[5]  = '{1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 4'd0};
    vecs[6]  = '{1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 4'd1};
    vecs[7]  = '{1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 4'd1};
    vecs[8]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 4'd1};
    vecs[9]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 4'd1};
    vecs[10] = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 4'd1};
    vecs[11] = '{1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 4'd1};
    vecs[12] = '{1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 4'd1};
    vecs[13] = '{1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 4'd1};
    vecs[14] = '{1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b1, 4'd1};
    vecs[15] = '{1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b0, 4'd1};
    vecs[16] = '{1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 4'd1};
    vecs[17] = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 4'd1};
    vecs[18] = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 4'd1};
    vecs[19] = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 4'd1};
    vecs[20] = '{1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 4'd1};
    vecs[21] = '{1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 4'd1};
    vecs[22] = '{1'b0, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b1, 4'd1};
    vecs[23] = '{1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b1, 4'd1};
    vecs[24] = '{1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b0, 4'd1};

    // Reset values
    doReset();
    checkOutput("rst_ack",   32'(ack_out),   32'd0);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_data",  32'(out_data),  32'd0);
    checkOutput("rst_err",   32'(err),       32'd0);
    checkOutput("rst_cnt",   32'(xfer_cnt),  32'd0);

    // Single transfer, violation with clear, and violation with set-wins
    $display("[TB] table vectors");
    for (int i = 0; i < 25; i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput($sformatf("vec%0d_ack", i),   32'(ack_out),   32'(vecs[i].ack));
      checkOutput($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].valid));
      checkOutput($sformatf("vec%0d_data", i),  32'(out_data),  32'(vecs[i].odata));
      checkOutput($sformatf("vec%0d_err", i),   32'(err),       32'(vecs[i].err));
      checkOutput($sformatf("vec%0d_cnt", i),   32'(xfer_cnt),  32'(vecs[i].cnt));
    end
    err_clr = 1'b0;

    // Backpressure: word held, no ack until the consumer is ready
    $display("[TB] backpressure");
    req_in    = 1'b1;
    data_in   = 8'hC3;
    out_ready = 1'b0;
    tick();
    tick();
    tick();
    checkOutput("bp_valid_rise", 32'(out_valid), 32'd1);
    data_in = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("bp_valid_hold", 32'(out_valid), 32'd1);
      checkOutput("bp_data_hold",  32'(out_data),  32'hC3);
      checkOutput("bp_no_ack",     32'(ack_out),   32'd0);
    end
    out_ready = 1'b1;
    tick();
    checkOutput("bp_ack",       32'(ack_out),   32'd1);
    checkOutput("bp_valid_low", 32'(out_valid), 32'd0);
    req_in    = 1'b0;
    out_ready = 1'b0;
    waitAck(1'b0, 10, "bp_ack_fall");
    checkOutput("bp_cnt", 32'(xfer_cnt), 32'd2);

    // Reset while acknowledging with req still high, then re-capture
    $display("[TB] reset in ACK");
    req_in    = 1'b1;
    data_in   = 8'h96;
    out_ready = 1'b1;
    tick();
    tick();
    tick();
    checkOutput("ra_valid", 32'(out_valid), 32'd1);
    tick();
    checkOutput("ra_ack", 32'(ack_out), 32'd1);
    #2;
    reset_ = 1'b0;
    #1;
    checkOutput("ra_async_ack",   32'(ack_out),   32'd0);
    checkOutput("ra_async_valid", 32'(out_valid), 32'd0);
    checkOutput("ra_async_data",  32'(out_data),  32'd0);
    checkOutput("ra_async_cnt",   32'(xfer_cnt),  32'd0);
    tick();
    reset_ = 1'b1;
    tick();
    tick();
    checkOutput("ra_valid_early", 32'(out_valid), 32'd0);
    tick();
    checkOutput("ra_recap_valid", 32'(out_valid), 32'd1);
    checkOutput("ra_recap_data",  32'(out_data),  32'h96);
    req_in = 1'b0;
    waitAck(1'b1, 5, "ra_ack_high");
    waitAck(1'b0, 10, "ra_ack_low");
    checkOutput("ra_cnt", 32'(xfer_cnt), 32'd1);
    checkOutput("ra_err", 32'(err),      32'd0);

    // Counter wrap with a 4-bit counter
    $display("[TB] counter wrap");
    doReset();
    for (int i = 0; i < 16; i++) doHandshake(8'(i));
    checkOutput("wrap_cnt16", 32'(xfer_cnt), 32'd0);
    doHandshake(8'h77);
    checkOutput("wrap_cnt17", 32'(xfer_cnt), 32'd1);
    out_ready = 1'b0;

    // Random sender delays against a random consumer
    $display("[TB] random traffic");
    senderDone = 1'b0;
    recvCount  = 0;
    fork
      begin
        for (int n = 0; n < 20; n++) begin
          int dly;
          logic [7:0] w;
          dly = $urandom_range(0, 20);
          for (int k = 0; k < dly; k++) tick();
          w = 8'($urandom_range(0, 255));
          data_in = w;
          sentQ.push_back(w);
          req_in = 1'b1;
          waitAck(1'b1, 200, "rnd_ack_high");
          req_in = 1'b0;
          waitAck(1'b0, 50, "rnd_ack_low");
        end
        senderDone = 1'b1;
      end
      begin
        while (!senderDone) begin
          @(negedge clk);
          if (out_valid && out_ready) begin
            logic [7:0] expw;
            expw = (sentQ.size() > 0) ? sentQ.pop_front() : 8'hXX;
            checkOutput("rnd_word", 32'(out_data), 32'(expw));
            recvCount++;
          end
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    checkOutput("rnd_count", 32'(recvCount), 32'd20);
    checkOutput("rnd_cnt",   32'(xfer_cnt),  32'd5);
    checkOutput("rnd_err",   32'(err),       32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
